task_dispatcher: RTL

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/task_dispatcher.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/task_dispatcher.sv
// Round-based task dispatcher: scans eight candidate slots, runs the best task for one time slice
// and relays host commands. Define DISPATCH_STATS_EN to build the dispatch/timeout counters.
module task_dispatcher #(
    parameter int unsigned SLICE_CYCLES = 1000,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        sched_en,
    input  logic [63:0] cand_bus,
    input  logic        exe_flag,
    input  logic        host_valid,
    input  logic [15:0] host_op,
    output logic        host_ready,
    output logic [15:0] out_op,
    output logic        busy,
    output logic [3:0]  cur_id,
    output logic [15:0] dispatch_count,
    output logic [15:0] timeout_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_ACK  = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;
    localparam logic [2:0] ST_HOST = 3'd7;

    localparam logic [3:0] OP_SUSPEND = 4'b0010;
    localparam logic [3:0] OP_KILL    = 4'b0100;
    localparam logic [3:0] OP_EXECUTE = 4'b0111;
    localparam logic [3:0] OP_FINISH  = 4'b1111;

    localparam logic [7:0]  WAIT_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [16:0] SLICE_LAST = 17'(SLICE_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic        found_q, found_d;
    logic [3:0]  best_prio_q, best_prio_d;
    logic [3:0]  best_id_q, best_id_d;
    logic [15:0] slice_q, slice_d;
    logic [7:0]  wait_q, wait_d;
    logic        hold_q, hold_d;
    logic [15:0] out_op_q, out_op_d;
    logic        host_ready_q, host_ready_d;
    logic        busy_q, busy_d;
    logic [3:0]  cur_id_q, cur_id_d;

    logic [7:0]  slot_val;
    logic        take;
    logic [3:0]  winner_id;
    logic [16:0] slice_inc;

    assign slot_val  = cand_bus[{slot_q, 3'b000} +: 8];
    // Strict '>' keeps the earliest slot on a priority tie.
    assign take      = (slot_val != 8'h00) && (!found_q || (slot_val[3:0] > best_prio_q));
    assign winner_id = take ? slot_val[7:4] : best_id_q;
    assign slice_inc = {1'b0, slice_q} + 17'd1;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        slot_d       = slot_q;
        found_d      = found_q;
        best_prio_d  = best_prio_q;
        best_id_d    = best_id_q;
        slice_d      = slice_q;
        wait_d       = wait_q;
        hold_d       = 1'b0;
        out_op_d     = 16'h0000;
        host_ready_d = 1'b0;
        busy_d       = busy_q;
        cur_id_d     = cur_id_q;

        case (state_q)
            ST_IDLE: begin
                // hold_q guarantees a NOP cycle after reset and after a Suspend/Kill.
                if (!hold_q) begin
                    if (host_valid) begin
                        state_d      = ST_HOST;
                        out_op_d     = host_op & 16'h0FFF;
                        host_ready_d = 1'b1;
                    end else if (sched_en) begin
                        state_d     = ST_SCAN;
                        slot_d      = 3'd0;
                        found_d     = 1'b0;
                        best_prio_d = 4'h0;
                        best_id_d   = 4'h0;
                    end
                end
            end
            ST_HOST: state_d = ST_IDLE;
            ST_SCAN: begin
                slot_d = slot_q + 3'd1;
                if (take) begin
                    found_d     = 1'b1;
                    best_prio_d = slot_val[3:0];
                    best_id_d   = slot_val[7:4];
                end
                if (slot_q == 3'd7) begin
                    if (found_q || take) begin
                        state_d  = ST_EXEC;
                        busy_d   = 1'b1;
                        cur_id_d = winner_id;
                        out_op_d = {4'h0, winner_id, OP_EXECUTE, 4'h0};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_ACK;
                wait_d  = 8'h00;
            end
            ST_ACK: begin
                if (exe_flag) begin
                    state_d = ST_RUN;
                    slice_d = 16'h0000;
                end else if (wait_q == WAIT_LAST) begin
                    state_d  = ST_IDLE;
                    out_op_d = {4'h0, cur_id_q, OP_SUSPEND, 4'h0};
                    hold_d   = 1'b1;
                    busy_d   = 1'b0;
                    cur_id_d = 4'h0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_RUN: begin
                slice_d = slice_inc[15:0];
                if (!exe_flag || (slice_inc >= SLICE_LAST)) begin
                    state_d  = ST_FIN;
                    out_op_d = {4'h0, cur_id_q, OP_FINISH, 4'h0};
                end
            end
            ST_FIN: begin
                state_d = ST_DONE;
                wait_d  = 8'h00;
            end
            ST_DONE: begin
                if (!exe_flag) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    cur_id_d = 4'h0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d  = ST_IDLE;
                    out_op_d = {4'h0, cur_id_q, OP_KILL, 4'h0};
                    hold_d   = 1'b1;
                    busy_d   = 1'b0;
                    cur_id_d = 4'h0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            slot_q       <= 3'd0;
            found_q      <= 1'b0;
            best_prio_q  <= 4'h0;
            best_id_q    <= 4'h0;
            slice_q      <= 16'h0000;
            wait_q       <= 8'h00;
            hold_q       <= 1'b1;
            out_op_q     <= 16'h0000;
            host_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            cur_id_q     <= 4'h0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            found_q      <= found_d;
            best_prio_q  <= best_prio_d;
            best_id_q    <= best_id_d;
            slice_q      <= slice_d;
            wait_q       <= wait_d;
            hold_q       <= hold_d;
            out_op_q     <= out_op_d;
            host_ready_q <= host_ready_d;
            busy_q       <= busy_d;
            cur_id_q     <= cur_id_d;
        end
    end

    assign out_op     = out_op_q;
    assign host_ready = host_ready_q;
    assign busy       = busy_q;
    assign cur_id     = cur_id_q;

`ifdef DISPATCH_STATS_EN
    logic [15:0] dispatch_cnt_q, timeout_cnt_q;
    logic        dispatch_hit, timeout_hit;

    assign dispatch_hit = (state_q == ST_DONE) && !exe_flag;
    assign timeout_hit  = (wait_q == WAIT_LAST) &&
                          (((state_q == ST_ACK) && !exe_flag) || ((state_q == ST_DONE) && exe_flag));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dispatch_cnt_q <= 16'h0000;
            timeout_cnt_q  <= 16'h0000;
        end else begin
            if (dispatch_hit && (dispatch_cnt_q != 16'hFFFF)) dispatch_cnt_q <= dispatch_cnt_q + 16'd1;
            if (timeout_hit && (timeout_cnt_q != 16'hFFFF))   timeout_cnt_q  <= timeout_cnt_q + 16'd1;
        end
    end

    assign dispatch_count = dispatch_cnt_q;
    assign timeout_count  = timeout_cnt_q;
`else
    assign dispatch_count = 16'h0000;
    assign timeout_count  = 16'h0000;
`endif

endmodule
